// File: rtl/vp_key_arbiter.sv
// Merges queued PS/2 key events and joystick numpad edges onto a single keymap
// ready/read handshake. Sources are served round-robin, with a fixed idle gap after each event.
module vp_key_arbiter #(
  parameter int PS2_FIFO_DEPTH = 4,
  parameter int GAP_CYCLES     = 1024,
  parameter int ACK_TIMEOUT    = 65535
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_stb_i,
  input  logic [7:0] ps2_ascii_i,
  input  logic       ps2_released_i,
  input  logic [9:0] joy_numpad_i,
  output logic       rx_data_ready_o,
  output logic [7:0] rx_ascii_o,
  output logic       rx_released_o,
  input  logic       rx_read_i,
  output logic       ps2_ovf_o,
  output logic       timeout_o
);

  localparam int AW = $clog2(PS2_FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t          state, state_nxt;
  logic            grant_joy, prefer_joy;
  logic            do_grant, grant_pick, pop_evt, to_evt;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   to_cnt;

  // PS/2 event queue: each entry is {ascii, released}
  logic [8:0]      fifo_mem [PS2_FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full, fifo_push, fifo_pop, ps2_valid;
  logic [8:0]      fifo_head;

  assign ps2_valid  = ps2_stb_i && (ps2_ascii_i != 8'h00);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
  assign fifo_pop   = pop_evt && !grant_joy;
  assign fifo_push  = ps2_valid && (!fifo_full || fifo_pop);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ps2_ovf_o <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      ps2_ovf_o <= ps2_valid && fifo_full && !fifo_pop;
    end
  end

  // NOTE: storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_sys) begin
    if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= {ps2_ascii_i, ps2_released_i};
  end

  // Joystick: report one changed bit at a time, lowest index first
  logic [9:0] joy_state, joy_diff;
  logic [3:0] joy_bit;
  logic       joy_hit, slot_valid, slot_rel, slot_pop;
  logic [7:0] slot_ascii, joy_ascii;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    joy_diff = joy_numpad_i ^ joy_state;
    joy_bit  = 4'd0;
    joy_hit  = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      if (joy_diff[i]) begin
        joy_bit = 4'(i);
        joy_hit = 1'b1;
      end
    end
  end

  assign joy_ascii = (joy_bit == 4'd9) ? 8'h30 : 8'h31 + {4'b0000, joy_bit};
  assign slot_pop  = pop_evt && grant_joy;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy_state  <= '0;
      slot_valid <= 1'b0;
      slot_ascii <= 8'h00;
      slot_rel   <= 1'b0;
    end else if (slot_valid) begin
      if (slot_pop) slot_valid <= 1'b0;
    end else if (joy_hit) begin
      slot_valid         <= 1'b1;
      slot_ascii         <= joy_ascii;
      slot_rel           <= ~joy_numpad_i[joy_bit];
      joy_state[joy_bit] <= joy_numpad_i[joy_bit];
    end
  end

  // Handshake FSM
  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    grant_pick = 1'b0;
    pop_evt    = 1'b0;
    to_evt     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty || slot_valid) begin
          do_grant   = 1'b1;
          grant_pick = slot_valid && (fifo_empty || prefer_joy);
          state_nxt  = PRESENT;
        end
      end
      PRESENT: begin
        if (rx_read_i) begin
          pop_evt   = 1'b1;
          state_nxt = GAP;
        end else if ((ACK_TIMEOUT != 0) && (to_cnt == TW'(ACK_TIMEOUT - 1))) begin
          pop_evt   = 1'b1;
          to_evt    = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state-holding registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant_joy     <= 1'b0;
      prefer_joy    <= 1'b0;
      rx_ascii_o    <= 8'h00;
      rx_released_o <= 1'b0;
      gap_cnt       <= '0;
      to_cnt        <= '0;
      timeout_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timeout_o <= to_evt;
      if (do_grant) begin
        grant_joy     <= grant_pick;
        prefer_joy    <= ~grant_pick;
        rx_ascii_o    <= grant_pick ? slot_ascii : fifo_head[8:1];
        rx_released_o <= grant_pick ? slot_rel : fifo_head[0];
      end
      if (state == PRESENT && state_nxt == PRESENT) begin
        if (to_cnt != {TW{1'b1}}) to_cnt <= to_cnt + TW'(1);
      end else begin
        to_cnt <= '0;
      end
      if (state == GAP && state_nxt == GAP) begin
        if (gap_cnt != {GW{1'b1}}) gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // Ready is decoded from the state register, so an async reset drops it at once
  assign rx_data_ready_o = (state == PRESENT);

endmodule

// File: tb/tb_vp_key_arbiter.sv
// Bench for vp_key_arbiter: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the arbitration rules.
module tb_vp_key_arbiter;

  localparam int DEPTH = 4;
  localparam int GAP   = 8;
  localparam int ACK   = 16;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_stb = 1'b0;
  logic [7:0] ps2_ascii = 8'h00;
  logic       ps2_rel = 1'b0;
  logic [9:0] joy = 10'h000;
  logic       rx_read = 1'b0;
  logic       rx_ready, rx_rel, ovf, tmo;
  logic [7:0] rx_ascii;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  vp_key_arbiter #(
    .PS2_FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ps2_stb_i(ps2_stb), .ps2_ascii_i(ps2_ascii), .ps2_released_i(ps2_rel),
    .joy_numpad_i(joy),
    .rx_data_ready_o(rx_ready), .rx_ascii_o(rx_ascii), .rx_released_o(rx_rel),
    .rx_read_i(rx_read), .ps2_ovf_o(ovf), .timeout_o(tmo)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: phases 0 = waiting, 1 = event shown, 2 = gap
  bit [8:0] m_q[$];
  bit [9:0] m_joy;
  bit       m_slot_v;
  bit [8:0] m_slot;
  int       m_phase, m_cnt;
  bit       m_prefer_joy, m_from_joy;
  bit [7:0] m_ascii;
  bit       m_rel, m_ovf, m_to;

  task automatic model_reset();
    m_q.delete();
    m_joy = '0; m_slot_v = 0; m_slot = '0;
    m_phase = 0; m_cnt = 0;
    m_prefer_joy = 0; m_from_joy = 0;
    m_ascii = 8'h00; m_rel = 0; m_ovf = 0; m_to = 0;
  endtask

  task automatic model_update();
    bit       slot_was = m_slot_v;
    bit       drop = 0;
    bit [9:0] diff;
    m_ovf = 0;
    m_to  = 0;
    case (m_phase)
      0: if (m_q.size() > 0 || m_slot_v) begin
           m_from_joy   = m_slot_v && (m_q.size() == 0 || m_prefer_joy);
           m_prefer_joy = !m_from_joy;
           {m_ascii, m_rel} = m_from_joy ? m_slot : m_q[0];
           m_phase = 1;
           m_cnt   = 0;
         end
      1: begin
           m_cnt++;
           if (rx_read) drop = 1;
           else if (m_cnt == ACK) begin drop = 1; m_to = 1; end
           if (drop) begin
             if (m_from_joy) m_slot_v = 0;
             else void'(m_q.pop_front());
             m_phase = 2;
             m_cnt   = 0;
           end
         end
      default: begin
           m_cnt++;
           if (m_cnt == GAP) m_phase = 0;
         end
    endcase
    if (ps2_stb && ps2_ascii != 8'h00) begin
      if (m_q.size() < DEPTH) m_q.push_back({ps2_ascii, ps2_rel});
      else m_ovf = 1;
    end
    diff = joy ^ m_joy;
    if (!slot_was && diff != 0) begin
      int n = 0;
      while (!diff[n]) n++;
      m_slot   = {8'(8'h30 + (n + 1) % 10), ~joy[n]};
      m_joy[n] = joy[n];
      m_slot_v = 1;
    end
  endtask

  task automatic compare_outs();
    check("outs", {20'd0, rx_ready, rx_ascii, rx_rel, ovf, tmo},
          {20'd0, m_phase == 1, m_ascii, m_rel, m_ovf, m_to});
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_update();
    cyc++;
    @(negedge clk_sys);
    compare_outs();
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_phase == 1) begin ok = 1; break; end
      step();
    end
    check({tag, "_wait"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic serve(input string tag, input int delay, input logic [7:0] ea, input logic er);
    wait_ready(tag);
    check({tag, "_ascii"}, {24'd0, rx_ascii}, {24'd0, ea});
    check({tag, "_rel"}, {31'd0, rx_rel}, {31'd0, er});
    repeat (delay) step();
    rx_read = 1'b1;
    step();
    rx_read = 1'b0;
    check({tag, "_drop"}, {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic pulse_ps2(input logic [7:0] a, input logic r);
    ps2_stb = 1'b1; ps2_ascii = a; ps2_rel = r;
    step();
    ps2_stb = 1'b0; ps2_ascii = 8'h00; ps2_rel = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 check("rst_async", {20'd0, rx_ready, rx_ascii, rx_rel, ovf, tmo}, 32'd0);
    model_reset();
    @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    compare_outs();
  endtask

  initial begin
    int ovf_seen;
    int quiet;
    model_reset();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    compare_outs();

    // PS/2 "a" press, read three cycles after ready, then the full gap
    pulse_ps2(8'h61, 1'b0);
    serve("t1", 3, 8'h61, 1'b0);
    repeat (GAP + 4) step();

    // joystick 1 and 3 pressed together, then released together
    joy = 10'h005;
    serve("t2a", 2, 8'h31, 1'b0);
    serve("t2b", 2, 8'h33, 1'b0);
    joy = 10'h000;
    serve("t2c", 1, 8'h31, 1'b1);
    serve("t2d", 1, 8'h33, 1'b1);
    repeat (GAP + 4) step();

    // both sources pending from reset: PS/2, joy, PS/2
    async_reset();
    ps2_stb = 1'b1; ps2_ascii = 8'h62; joy = 10'h200;
    step();
    ps2_ascii = 8'h63;
    step();
    ps2_stb = 1'b0; ps2_ascii = 8'h00;
    serve("t3a", 1, 8'h62, 1'b0);
    serve("t3b", 1, 8'h30, 1'b0);
    serve("t3c", 1, 8'h63, 1'b0);
    joy = 10'h000;
    serve("t3d", 1, 8'h30, 1'b1);
    repeat (GAP + 4) step();

    // five strobes into a four-entry queue
    ovf_seen = 0;
    for (int i = 0; i < 5; i++) begin
      pulse_ps2(8'h64 + 8'(i), 1'(i & 1));
      if (ovf) ovf_seen++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (ovf) ovf_seen++;
    end
    check("t4_ovf_count", ovf_seen, 1);
    for (int i = 0; i < 4; i++) serve("t4", 1, 8'h64 + 8'(i), 1'(i & 1));
    repeat (GAP + 4) step();

    // no read: dropped after ACK cycles, next event still delivered
    pulse_ps2(8'h78, 1'b0);
    wait_ready("t5");
    repeat (ACK - 1) step();
    check("t5_still", {31'd0, rx_ready}, 32'd1);
    step();
    check("t5_to", {30'd0, rx_ready, tmo}, 32'd1);
    pulse_ps2(8'h79, 1'b1);
    serve("t5b", 0, 8'h79, 1'b1);
    repeat (GAP + 4) step();

    // reset while a held joystick key is presented
    joy = 10'h001;
    wait_ready("t6");
    check("t6_pre", {24'd0, rx_ascii}, 32'h31);
    repeat (2) step();
    async_reset();
    serve("t6b", 2, 8'h31, 1'b0);
    joy = 10'h000;
    serve("t6c", 2, 8'h31, 1'b1);

    // random traffic
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) quiet = ($urandom_range(0, 3) == 0);
      ps2_stb   = ($urandom_range(0, 5) == 0);
      ps2_ascii = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ps2_rel   = 1'($urandom);
      rx_read   = !quiet && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) joy[$urandom_range(0, 9)] ^= 1'b1;
      step();
    end
    ps2_stb = 1'b0; ps2_ascii = 8'h00; rx_read = 1'b1;
    repeat (300) step();
    rx_read = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
